// File: rtl/ctrl_pipe_pkg.sv
// rtl/ctrl_pipe_pkg.sv - control encodings and per-stage control bundles for ctrl_pipe
package ctrl_pipe_pkg;

  typedef enum logic [1:0] {BCN = 2'b00, BCB = 2'b01, BCJAL = 2'b10, BCJALR = 2'b11} branch_e;
  typedef enum logic [1:0] {REGALU = 2'b00, REGMEM = 2'b01, RPC = 2'b10} mem2reg_e;
  typedef enum logic [1:0] {FWD_RF = 2'b00, FWD_WB = 2'b01, FWD_MEM = 2'b10} fwd_e;

  typedef struct packed {
    logic       alusrc;
    logic [1:0] aluop;
    logic [1:0] branch;
    logic       memread;
    logic       memwrite;
    logic       regwrite;
    logic [1:0] mem2reg;
  } ex_ctrl_t;

  typedef struct packed {
    logic       memread;
    logic       memwrite;
    logic       regwrite;
    logic [1:0] mem2reg;
  } mem_ctrl_t;

  typedef struct packed {
    logic       regwrite;
    logic [1:0] mem2reg;
  } wb_ctrl_t;

  localparam ex_ctrl_t EX_BUBBLE = '{alusrc: 1'b0, aluop: 2'b00, branch: BCN, memread: 1'b0,
                                     memwrite: 1'b0, regwrite: 1'b0, mem2reg: REGALU};

  // EX/MEM hit outranks MEM/WB hit: it holds the younger result.
  function automatic logic [1:0] fwd_pick(input logic mem_hit, input logic wb_hit);
    if (mem_hit) return FWD_MEM;
    if (wb_hit)  return FWD_WB;
    return FWD_RF;
  endfunction

endpackage

// File: rtl/ctrl_pipe_if.sv
// rtl/ctrl_pipe_if.sv - decoder bundle in, stage controls and hazard/forward selects out
interface ctrl_pipe_if #(parameter int REG_W = 5);

  logic             id_alusrc;
  logic [1:0]       id_mem2reg;
  logic             id_regwrite;
  logic             id_memread;
  logic             id_memwrite;
  logic [1:0]       id_branch;
  logic [1:0]       id_aluop;
  logic [REG_W-1:0] id_rs1;
  logic [REG_W-1:0] id_rs2;
  logic [REG_W-1:0] id_rd;
  logic             ex_take;

  logic             pc_write;
  logic             ifid_write;
  logic             ifid_flush;
  logic             ex_alusrc;
  logic [1:0]       ex_aluop;
  logic [1:0]       ex_branch;
  logic             mem_memread;
  logic             mem_memwrite;
  logic             wb_regwrite;
  logic [1:0]       wb_mem2reg;
  logic [REG_W-1:0] wb_rd;
  logic [1:0]       fwd_a;
  logic [1:0]       fwd_b;

  modport master (
    output id_alusrc, id_mem2reg, id_regwrite, id_memread, id_memwrite, id_branch, id_aluop,
           id_rs1, id_rs2, id_rd, ex_take,
    input  pc_write, ifid_write, ifid_flush, ex_alusrc, ex_aluop, ex_branch, mem_memread,
           mem_memwrite, wb_regwrite, wb_mem2reg, wb_rd, fwd_a, fwd_b
  );

  modport slave (
    input  id_alusrc, id_mem2reg, id_regwrite, id_memread, id_memwrite, id_branch, id_aluop,
           id_rs1, id_rs2, id_rd, ex_take,
    output pc_write, ifid_write, ifid_flush, ex_alusrc, ex_aluop, ex_branch, mem_memread,
           mem_memwrite, wb_regwrite, wb_mem2reg, wb_rd, fwd_a, fwd_b
  );

endinterface

// File: rtl/ctrl_pipe_hazard_fwd_unit.sv
// rtl/ctrl_pipe_hazard_fwd_unit.sv - combinational load-use stall, flush bubble and forward selects
module ctrl_pipe_hazard_fwd_unit
  import ctrl_pipe_pkg::*;
#(
  parameter int REG_W = 5
) (
  input  logic             ex_memread,
  input  logic [REG_W-1:0] ex_rd,
  input  logic [REG_W-1:0] ex_rs1,
  input  logic [REG_W-1:0] ex_rs2,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             ex_take,
  input  logic             mem_regwrite,
  input  logic [REG_W-1:0] mem_rd,
  input  logic             wb_regwrite,
  input  logic [REG_W-1:0] wb_rd,
  output logic             stall,
  output logic             bubble,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b
);

  logic load_use;
  logic mem_live;
  logic wb_live;

  assign load_use = ex_memread && (ex_rd != '0) && ((ex_rd == id_rs1) || (ex_rd == id_rs2));
  // A taken transfer discards the ID instruction, so its stall would be pointless.
  assign stall    = load_use && !ex_take;
  assign bubble   = stall || ex_take;

  assign mem_live = mem_regwrite && (mem_rd != '0);
  assign wb_live  = wb_regwrite && (wb_rd != '0);

  assign fwd_a = fwd_pick(mem_live && (mem_rd == ex_rs1), wb_live && (wb_rd == ex_rs1));
  assign fwd_b = fwd_pick(mem_live && (mem_rd == ex_rs2), wb_live && (wb_rd == ex_rs2));

endmodule

// File: rtl/ctrl_pipe.sv
// rtl/ctrl_pipe.sv - ID/EX, EX/MEM, MEM/WB control registers with hazard and forward control
// Optional CTRL_PIPE_PERF_EN adds stall_cnt/flush_cnt event counters.
module ctrl_pipe
  import ctrl_pipe_pkg::*;
#(
  parameter int REG_W = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  ctrl_pipe_if.slave  bus
`ifdef CTRL_PIPE_PERF_EN
  ,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt
`endif
);

  ex_ctrl_t         idex_ctrl_q, idex_ctrl_d;
  logic [REG_W-1:0] idex_rs1_q, idex_rs1_d, idex_rs2_q, idex_rs2_d, idex_rd_q, idex_rd_d;
  mem_ctrl_t        exmem_ctrl_q, exmem_ctrl_d;
  logic [REG_W-1:0] exmem_rd_q, exmem_rd_d;
  wb_ctrl_t         memwb_ctrl_q, memwb_ctrl_d;
  logic [REG_W-1:0] memwb_rd_q, memwb_rd_d;

  logic stall;
  logic bubble;

  ctrl_pipe_hazard_fwd_unit #(.REG_W(REG_W)) u_hazard_fwd (
    .ex_memread   (idex_ctrl_q.memread),
    .ex_rd        (idex_rd_q),
    .ex_rs1       (idex_rs1_q),
    .ex_rs2       (idex_rs2_q),
    .id_rs1       (bus.id_rs1),
    .id_rs2       (bus.id_rs2),
    .ex_take      (bus.ex_take),
    .mem_regwrite (exmem_ctrl_q.regwrite),
    .mem_rd       (exmem_rd_q),
    .wb_regwrite  (memwb_ctrl_q.regwrite),
    .wb_rd        (memwb_rd_q),
    .stall        (stall),
    .bubble       (bubble),
    .fwd_a        (bus.fwd_a),
    .fwd_b        (bus.fwd_b)
  );

  always_comb begin
    idex_ctrl_d = '{alusrc: bus.id_alusrc, aluop: bus.id_aluop, branch: bus.id_branch,
                    memread: bus.id_memread, memwrite: bus.id_memwrite,
                    regwrite: bus.id_regwrite, mem2reg: bus.id_mem2reg};
    idex_rs1_d  = bus.id_rs1;
    idex_rs2_d  = bus.id_rs2;
    idex_rd_d   = bus.id_rd;
    // Bubble overrides every field, including x decoder outputs for unknown opcodes.
    if (bubble) begin
      idex_ctrl_d = EX_BUBBLE;
      idex_rs1_d  = '0;
      idex_rs2_d  = '0;
      idex_rd_d   = '0;
    end
    exmem_ctrl_d = '{memread: idex_ctrl_q.memread, memwrite: idex_ctrl_q.memwrite,
                     regwrite: idex_ctrl_q.regwrite, mem2reg: idex_ctrl_q.mem2reg};
    exmem_rd_d   = idex_rd_q;
    memwb_ctrl_d = '{regwrite: exmem_ctrl_q.regwrite, mem2reg: exmem_ctrl_q.mem2reg};
    memwb_rd_d   = exmem_rd_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idex_ctrl_q  <= EX_BUBBLE;
      idex_rs1_q   <= '0;
      idex_rs2_q   <= '0;
      idex_rd_q    <= '0;
      exmem_ctrl_q <= '0;
      exmem_rd_q   <= '0;
      memwb_ctrl_q <= '0;
      memwb_rd_q   <= '0;
    end else begin
      idex_ctrl_q  <= idex_ctrl_d;
      idex_rs1_q   <= idex_rs1_d;
      idex_rs2_q   <= idex_rs2_d;
      idex_rd_q    <= idex_rd_d;
      exmem_ctrl_q <= exmem_ctrl_d;
      exmem_rd_q   <= exmem_rd_d;
      memwb_ctrl_q <= memwb_ctrl_d;
      memwb_rd_q   <= memwb_rd_d;
    end
  end

  assign bus.pc_write     = !stall;
  assign bus.ifid_write   = !stall;
  assign bus.ifid_flush   = bus.ex_take;
  assign bus.ex_alusrc    = idex_ctrl_q.alusrc;
  assign bus.ex_aluop     = idex_ctrl_q.aluop;
  assign bus.ex_branch    = idex_ctrl_q.branch;
  assign bus.mem_memread  = exmem_ctrl_q.memread;
  assign bus.mem_memwrite = exmem_ctrl_q.memwrite;
  assign bus.wb_regwrite  = memwb_ctrl_q.regwrite;
  assign bus.wb_mem2reg   = memwb_ctrl_q.mem2reg;
  assign bus.wb_rd        = memwb_rd_q;

`ifdef CTRL_PIPE_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q + {31'd0, stall};
    flush_cnt_d = flush_cnt_q + {31'd0, bus.ex_take};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif

endmodule
